clic_arbiter: RTL and testbench

//  Interrupt arbiter and nesting-level scheduler for the n_clic core. It latches peripheral

---
 rtl/clic_arbiter.sv | 206 ++++++++++++++++++++
 tb/tb_clic_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/clic_arbiter.sv
// clic_arbiter: interrupt arbiter and nesting-level scheduler for the n_clic core.
// Optional feature macro: CLIC_TAIL_CHAIN_EN adds an atomic pop+take on mret ("tail chain").
module clic_arbiter #(
    parameter int VecLen     = 8,
    parameter int PrioWidth  = 3,
    parameter int StackDepth = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [VecLen-1:0]               irq_req,
    input  logic                            cfg_we,
    input  logic [$clog2(VecLen)-1:0]       cfg_idx,
    input  logic [PrioWidth-1:0]            cfg_prio,
    input  logic                            cfg_en,
    input  logic                            cfg_pset,
    input  logic                            cfg_pclr,
    output logic                            take_valid,
    output logic [$clog2(VecLen)-1:0]       take_id,
    output logic [PrioWidth-1:0]            take_prio,
    input  logic                            take_ready,
    input  logic                            mret,
    output logic [PrioWidth-1:0]            level,
    output logic [$clog2(StackDepth+1)-1:0] depth,
`ifdef CLIC_TAIL_CHAIN_EN
    output logic                            tail_chain,
`endif
    output logic                            stack_err
);
    localparam int IdxW = $clog2(VecLen);
    localparam int DepW = $clog2(StackDepth + 1);
    localparam int SAW  = (StackDepth > 1) ? $clog2(StackDepth) : 1;

    typedef struct packed {
        logic                 valid;
        logic [IdxW-1:0]      id;
        logic [PrioWidth-1:0] prio;
    } pick_t;

    // Highest priority wins; strict compare keeps the lowest index on ties.
    function automatic pick_t pick(input logic [VecLen-1:0] elig,
                                   input logic [VecLen*PrioWidth-1:0] pf);
        pick_t r;
        r = '0;
        for (int i = 0; i < VecLen; i++) begin
            if (elig[i] && (!r.valid || pf[i*PrioWidth +: PrioWidth] > r.prio)) begin
                r.valid = 1'b1;
                r.id    = IdxW'(i);
                r.prio  = pf[i*PrioWidth +: PrioWidth];
            end
        end
        return r;
    endfunction

    logic [VecLen-1:0]           irq_q_reg, pending_reg, pending_next, en_reg;
    logic [VecLen-1:0]           rise_vec, set_vec, clr_vec, elig_lvl;
    logic [PrioWidth-1:0]        prio_reg [VecLen];
    logic [PrioWidth-1:0]        stack_reg [StackDepth];
    logic [VecLen*PrioWidth-1:0] prio_flat;
    logic [PrioWidth-1:0]        level_reg, level_next, stack_top;
    logic [DepW-1:0]             depth_reg, depth_next;
    logic                        stack_err_reg, stack_err_next, push;
    logic                        take_valid_reg, take_valid_next, reeval_reg, reeval_next;
    logic [IdxW-1:0]             take_id_reg, take_id_next, tc_id;
    logic [PrioWidth-1:0]        take_prio_reg, take_prio_next, tc_prio;
    logic                        hs, tc_fire;
    pick_t                       pick_lvl;

    assign stack_top = stack_reg[SAW'(depth_reg - DepW'(1))];
    // mret takes precedence: a handshake in an mret cycle is ignored and its pending bit kept.
    assign hs        = take_valid_reg & take_ready & ~mret;
    assign pick_lvl  = pick(elig_lvl, prio_flat);

`ifdef CLIC_TAIL_CHAIN_EN
    logic [VecLen-1:0] elig_top;
    pick_t             pick_top;
    logic              tc_reg;
    assign pick_top   = pick(elig_top, prio_flat);
    assign tc_fire    = mret & (depth_reg != '0) & pick_top.valid;
    assign tc_id      = pick_top.id;
    assign tc_prio    = pick_top.prio;
    assign tail_chain = tc_reg;
`else
    assign tc_fire = 1'b0;
    assign tc_id   = '0;
    assign tc_prio = '0;
`endif

    // Per-source edge detect, eligibility and pending update (set beats clear).
    for (genvar gi = 0; gi < VecLen; gi++) begin : g_src
        assign prio_flat[gi*PrioWidth +: PrioWidth] = prio_reg[gi];
        assign rise_vec[gi] = irq_req[gi] & ~irq_q_reg[gi];
        assign elig_lvl[gi] = pending_reg[gi] & en_reg[gi] & (prio_reg[gi] > level_reg);
        assign set_vec[gi]  = rise_vec[gi] | (cfg_we & cfg_pset & (cfg_idx == IdxW'(gi)));
        assign clr_vec[gi]  = (hs & (take_id_reg == IdxW'(gi)))
                            | (tc_fire & (tc_id == IdxW'(gi)))
                            | (cfg_we & cfg_pclr & (cfg_idx == IdxW'(gi)));
        assign pending_next[gi] = set_vec[gi] | (pending_reg[gi] & ~clr_vec[gi]);
`ifdef CLIC_TAIL_CHAIN_EN
        assign elig_top[gi] = pending_reg[gi] & en_reg[gi] & (prio_reg[gi] > stack_top);
`endif
    end

    // Level/depth stack control: mret pops (or tail-chains), handshake pushes.
    always_comb begin
        level_next     = level_reg;
        depth_next     = depth_reg;
        stack_err_next = stack_err_reg;
        push           = 1'b0;
        if (mret) begin
            if (depth_reg == '0) begin
                stack_err_next = 1'b1;
            end else if (tc_fire) begin
                level_next = tc_prio;
            end else begin
                level_next = stack_top;
                depth_next = depth_reg - DepW'(1);
            end
        end else if (hs) begin
            push       = 1'b1;
            level_next = take_prio_reg;
            depth_next = depth_reg + DepW'(1);
        end
    end

    // Offer register: drop after handshake/mret/full stack, hold while stalled, else arbitrate.
    always_comb begin
        take_valid_next = 1'b0;
        take_id_next    = take_id_reg;
        take_prio_next  = take_prio_reg;
        reeval_next     = cfg_we & take_valid_reg & (cfg_idx == take_id_reg);
        if (tc_fire) begin
            take_id_next   = tc_id;
            take_prio_next = tc_prio;
        end else if (hs || mret || depth_reg == DepW'(StackDepth)) begin
            take_valid_next = 1'b0;
        end else if (take_valid_reg && !take_ready && !reeval_reg) begin
            take_valid_next = 1'b1;
            if (pick_lvl.valid && pick_lvl.prio > take_prio_reg) begin
                take_id_next   = pick_lvl.id;
                take_prio_next = pick_lvl.prio;
            end
        end else begin
            take_valid_next = pick_lvl.valid;
            if (pick_lvl.valid) begin
                take_id_next   = pick_lvl.id;
                take_prio_next = pick_lvl.prio;
            end
        end
    end

    // Source state: request sampler, pending, per-source config.
    // The sampler resets to all-ones so a request already high at reset release is not an edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_q_reg   <= '1;
            pending_reg <= '0;
            en_reg      <= '0;
            for (int i = 0; i < VecLen; i++) prio_reg[i] <= '0;
        end else begin
            irq_q_reg   <= irq_req;
            pending_reg <= pending_next;
            if (cfg_we) begin
                prio_reg[cfg_idx] <= cfg_prio;
                en_reg[cfg_idx]   <= cfg_en;
            end
        end
    end

    // Nesting state and registered offer outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < StackDepth; i++) stack_reg[i] <= '0;
            level_reg      <= '0;
            depth_reg      <= '0;
            stack_err_reg  <= 1'b0;
            take_valid_reg <= 1'b0;
            take_id_reg    <= '0;
            take_prio_reg  <= '0;
            reeval_reg     <= 1'b0;
        end else begin
            if (push) stack_reg[SAW'(depth_reg)] <= level_reg;
            level_reg      <= level_next;
            depth_reg      <= depth_next;
            stack_err_reg  <= stack_err_next;
            take_valid_reg <= take_valid_next;
            take_id_reg    <= take_id_next;
            take_prio_reg  <= take_prio_next;
            reeval_reg     <= reeval_next;
        end
    end

`ifdef CLIC_TAIL_CHAIN_EN
    // One-cycle tail-chain pulse, aligned with the updated take_id/take_prio.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) tc_reg <= 1'b0;
        else        tc_reg <= tc_fire;
    end
`endif

    assign take_valid = take_valid_reg;
    assign take_id    = take_id_reg;
    assign take_prio  = take_prio_reg;
    assign level      = level_reg;
    assign depth      = depth_reg;
    assign stack_err  = stack_err_reg;
endmodule

// File: tb/tb_clic_arbiter.sv
// Directed testbench for clic_arbiter (default build; tail-chain scenario when CLIC_TAIL_CHAIN_EN).
module tb_clic_arbiter;
    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] irq_req;
    logic       cfg_we, cfg_en, cfg_pset, cfg_pclr;
    logic [2:0] cfg_idx, cfg_prio;
    logic       take_valid, take_ready, mret, stack_err;
    logic [2:0] take_id, take_prio, level, depth;
`ifdef CLIC_TAIL_CHAIN_EN
    logic       tail_chain;
`endif
    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    clic_arbiter #(.VecLen(8), .PrioWidth(3), .StackDepth(4)) dut (
        .clk(clk), .reset(reset), .irq_req(irq_req),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_prio(cfg_prio), .cfg_en(cfg_en),
        .cfg_pset(cfg_pset), .cfg_pclr(cfg_pclr),
        .take_valid(take_valid), .take_id(take_id), .take_prio(take_prio),
        .take_ready(take_ready), .mret(mret), .level(level), .depth(depth),
`ifdef CLIC_TAIL_CHAIN_EN
        .tail_chain(tail_chain),
`endif
        .stack_err(stack_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input int idx, input int prio, input bit en, input bit pset, input bit pclr);
        cfg_we = 1'b1; cfg_idx = 3'(idx); cfg_prio = 3'(prio);
        cfg_en = en; cfg_pset = pset; cfg_pclr = pclr;
        tick();
        cfg_we = 1'b0; cfg_pset = 1'b0; cfg_pclr = 1'b0;
    endtask

    task automatic take();
        take_ready = 1'b1; tick(); take_ready = 1'b0;
    endtask

    task automatic do_mret();
        mret = 1'b1; tick(); mret = 1'b0;
    endtask

    task automatic chk_offer(input string tag, input bit v, input int id, input int prio);
        check({tag, ".valid"}, take_valid, v);
        if (v) begin
            check({tag, ".id"}, take_id, id);
            check({tag, ".prio"}, take_prio, prio);
        end
    endtask

    task automatic chk_lvl(input string tag, input int lv, input int dp);
        check({tag, ".level"}, level, lv);
        check({tag, ".depth"}, depth, dp);
    endtask

    initial begin
        reset = 1'b0; irq_req = 8'hFF; cfg_we = 0; cfg_idx = 0; cfg_prio = 0;
        cfg_en = 0; cfg_pset = 0; cfg_pclr = 0; take_ready = 0; mret = 0;
        repeat (3) tick();
        chk_offer("rst", 1'b0, 0, 0);
        check("rst.id", take_id, 0);
        check("rst.prio", take_prio, 0);
        chk_lvl("rst", 0, 0);
        check("rst.err", stack_err, 0);

        // Release with requests held high: no edge, so nothing pends even once enabled.
        reset = 1'b1;
        tick();
        cfg(0, 3, 1'b1, 1'b0, 1'b0);
        tick(); tick();
        chk_offer("rst_nopend", 1'b0, 0, 0);
        irq_req = 8'h00;
        tick();

        // Timer take: pulse irq_req[0], offer two edges later.
        irq_req = 8'h01; tick(); irq_req = 8'h00;
        chk_offer("timer_lat1", 1'b0, 0, 0);
        tick();
        chk_offer("timer_offer", 1'b1, 0, 3);
        tick();
        chk_offer("timer_hold", 1'b1, 0, 3);
        take();
        chk_lvl("timer_take", 3, 1);
        chk_offer("timer_drop", 1'b0, 0, 0);

`ifndef CLIC_TAIL_CHAIN_EN
        // Nest + tie: idx2 and idx5 both prio5, lowest index wins.
        cfg(2, 5, 1'b1, 1'b0, 1'b0);
        cfg(5, 5, 1'b1, 1'b0, 1'b0);
        irq_req = 8'h24; tick(); irq_req = 8'h00;
        tick();
        chk_offer("tie_offer", 1'b1, 2, 5);
        take();
        chk_lvl("tie_take", 5, 2);
        tick();
        chk_offer("tie_masked", 1'b0, 0, 0);
        do_mret();
        chk_lvl("tie_mret", 3, 1);
        chk_offer("tie_mret_drop", 1'b0, 0, 0);
        tick();
        chk_offer("tie_second", 1'b1, 5, 5);
        take();
        chk_lvl("tie_take2", 5, 2);
        do_mret(); chk_lvl("tie_mret2", 3, 1);
        do_mret(); chk_lvl("tie_mret3", 0, 0);

        // Masking: prio2 pending under level3 waits for return to level0.
        irq_req = 8'h01; tick(); irq_req = 8'h00;
        tick();
        chk_offer("mask_timer", 1'b1, 0, 3);
        take();
        chk_lvl("mask_in", 3, 1);
        cfg(1, 2, 1'b1, 1'b1, 1'b0);
        tick(); tick();
        chk_offer("mask_hold", 1'b0, 0, 0);
        do_mret();
        chk_lvl("mask_mret", 0, 0);
        chk_offer("mask_mret_drop", 1'b0, 0, 0);
        tick();
        chk_offer("mask_offer", 1'b1, 1, 2);
        take(); chk_lvl("mask_take", 2, 1);
        do_mret(); chk_lvl("mask_back", 0, 0);

        // Overflow: four nested takes with prio 1..4 fill the stack.
        begin
            int ids[4] = '{3, 4, 6, 7};
            for (int k = 0; k < 4; k++) begin
                cfg(ids[k], k + 1, 1'b1, 1'b1, 1'b0);
                tick();
                chk_offer($sformatf("ovf_offer%0d", k), 1'b1, ids[k], k + 1);
                take();
                chk_lvl($sformatf("ovf_take%0d", k), k + 1, k + 1);
            end
        end
        cfg(2, 7, 1'b1, 1'b1, 1'b0);
        tick(); tick();
        chk_offer("ovf_block", 1'b0, 0, 0);
        chk_lvl("ovf_full", 4, 4);
        do_mret();
        chk_lvl("ovf_pop", 3, 3);
        tick();
        chk_offer("ovf_release", 1'b1, 2, 7);
        // Clearing the offered source while offered: hold one cycle, then re-evaluate.
        cfg(2, 7, 1'b1, 1'b0, 1'b1);
        chk_offer("reeval_hold", 1'b1, 2, 7);
        tick();
        chk_offer("reeval_drop", 1'b0, 0, 0);
        do_mret(); chk_lvl("unwind2", 2, 2);
        do_mret(); chk_lvl("unwind1", 1, 1);
        do_mret(); chk_lvl("unwind0", 0, 0);
        check("err_before", stack_err, 0);
        do_mret();
        check("err_set", stack_err, 1);
        chk_lvl("err_level", 0, 0);

        // mret and handshake together: mret wins, pending kept.
        cfg(0, 3, 1'b1, 1'b1, 1'b0);
        tick();
        chk_offer("mh_timer", 1'b1, 0, 3);
        take();
        chk_lvl("mh_in", 3, 1);
        cfg(5, 6, 1'b1, 1'b1, 1'b0);
        tick();
        chk_offer("mh_offer", 1'b1, 5, 6);
        take_ready = 1'b1; mret = 1'b1; tick(); take_ready = 1'b0; mret = 1'b0;
        chk_lvl("mh_both", 0, 0);
        chk_offer("mh_drop", 1'b0, 0, 0);
        tick();
        chk_offer("mh_keep", 1'b1, 5, 6);
        take(); chk_lvl("mh_take", 6, 1);
        do_mret(); chk_lvl("mh_out", 0, 0);
        check("err_sticky", stack_err, 1);
`else
        // Tail chain: return from level4 straight into pending idx3 prio2.
        do_mret();
        chk_lvl("tc_pre", 0, 0);
        cfg(4, 4, 1'b1, 1'b1, 1'b0);
        tick();
        chk_offer("tc_offer", 1'b1, 4, 4);
        take();
        chk_lvl("tc_in", 4, 1);
        cfg(3, 2, 1'b1, 1'b1, 1'b0);
        tick();
        chk_offer("tc_masked", 1'b0, 0, 0);
        do_mret();
        check("tc_pulse", tail_chain, 1);
        check("tc_id", take_id, 3);
        check("tc_prio", take_prio, 2);
        chk_lvl("tc_chain", 2, 1);
        tick();
        check("tc_pulse_end", tail_chain, 0);
        chk_offer("tc_no_offer", 1'b0, 0, 0);
        do_mret();
        chk_lvl("tc_out", 0, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
